sw_parity_popcount: RTL and testbench

//   Parametrised switch-bank monitor for the Basys3 board. Each switch is

---
 rtl/sw_parity_popcount.sv | 85 ++++++++
 tb/tb_sw_parity_popcount.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_parity_popcount.sv
// Switch-bank monitor: per-bit 2-flop sync and debounce, then a registered
// popcount, a parity LED with selectable sense, and a count-change strobe.
module sw_parity_popcount #(
  parameter  int N_SW            = 16,
  parameter  int DEBOUNCE_CYCLES = 1_000_000,
  parameter  int DB_W            = 20,
  localparam int CNT_W           = $clog2(N_SW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw,
  input  logic             mode,
  output logic [CNT_W-1:0] count,
  output logic             led,
  output logic             changed
);

  localparam logic [DB_W-1:0] TC = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  r_sw_meta;
  logic [N_SW-1:0]  r_sw_s;
  logic [N_SW-1:0]  r_db;
  logic             r_mode_meta;
  logic             r_mode_s;
  logic [DB_W-1:0]  r_cnt [N_SW];
  logic [CNT_W-1:0] r_count;
  logic             r_led;
  logic             r_changed;
  logic [CNT_W-1:0] w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta   <= '0;
      r_sw_s      <= '0;
      r_mode_meta <= 1'b0;
      r_mode_s    <= 1'b0;
    end else begin
      r_sw_meta   <= sw;
      r_sw_s      <= r_sw_meta;
      r_mode_meta <= mode;
      r_mode_s    <= r_mode_meta;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db <= '0;
      for (int i = 0; i < N_SW; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (r_sw_s[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == TC) begin
          r_db[i]  <= r_sw_s[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_SW; i++) w_pop = w_pop + CNT_W'(r_db[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_led     <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_count   <= w_pop;
      r_led     <= (^r_db) ^ r_mode_s;
      r_changed <= (w_pop != r_count);
    end
  end

  assign count   = r_count;
  assign led     = r_led;
  assign changed = r_changed;

endmodule

// File: tb/tb_sw_parity_popcount.sv
// Bench for sw_parity_popcount: directed latency/boundary scenarios on 8- and
// 16-switch instances, then random bouncing input against a reference model.
module tb_sw_parity_popcount;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [7:0] sw8;
  logic       mode8;
  logic [3:0] count8;
  logic       led8;
  logic       changed8;
  logic [15:0] sw16;
  logic        mode16;
  logic [4:0]  count16;
  logic        led16;
  logic        changed16;

  int checks = 0;
  int errors = 0;

  sw_parity_popcount #(.N_SW(8), .DEBOUNCE_CYCLES(D), .DB_W(4)) dut8 (
    .clk(clk), .rst(rst), .sw(sw8), .mode(mode8),
    .count(count8), .led(led8), .changed(changed8)
  );

  sw_parity_popcount #(.N_SW(16), .DEBOUNCE_CYCLES(D), .DB_W(4)) dut16 (
    .clk(clk), .rst(rst), .sw(sw16), .mode(mode16),
    .count(count16), .led(led16), .changed(changed16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model of the 8-switch instance: a switch level is accepted once
  // its synchronised value has disagreed with the accepted level for D samples.
  logic [7:0] m_sw_q [$];
  logic       m_mode_q [$];
  logic [7:0] m_db;
  int         m_run [8];
  int         m_count;
  logic       m_led;
  logic       m_changed;

  always @(posedge clk) begin
    logic [7:0] sw_s;
    logic       mode_s;
    if (rst) begin
      m_sw_q    = {8'h00, 8'h00};
      m_mode_q  = {1'b0, 1'b0};
      m_db      = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_count   = 0;
      m_led     = 1'b0;
      m_changed = 1'b0;
    end else begin
      sw_s   = m_sw_q[1];
      mode_s = m_mode_q[1];
      m_changed = ($countones(m_db) != m_count);
      m_count   = $countones(m_db);
      m_led     = (m_count % 2 == 1) ^ mode_s;
      for (int i = 0; i < 8; i++) begin
        if (sw_s[i] == m_db[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= D) begin
          m_db[i]  = sw_s[i];
          m_run[i] = 0;
        end else m_run[i] = m_run[i] + 1;
      end
      m_sw_q.push_front(sw8);
      void'(m_sw_q.pop_back());
      m_mode_q.push_front(mode8);
      void'(m_mode_q.pop_back());
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (count8 !== 4'd0 || led8 !== 1'b0 || changed8 !== 1'b0) begin
        errors++;
        $display("FAIL reset8 cyc %0d: count=%0d led=%b changed=%b, want 0/0/0", k, count8, led8, changed8);
      end
      checks++;
      if (count16 !== 5'd0 || led16 !== 1'b0 || changed16 !== 1'b0) begin
        errors++;
        $display("FAIL reset16 cyc %0d: count=%0d led=%b changed=%b, want 0/0/0", k, count16, led16, changed16);
      end
      if (k == 3) rst = 1'b0;
    end
  endtask

  task automatic test_single_bit;
    sw8 = 8'h01;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (count8 !== ((k >= 7) ? 4'd1 : 4'd0) || led8 !== (k >= 7) || changed8 !== (k == 7)) begin
        errors++;
        $display("FAIL single_bit edge %0d: count=%0d led=%b changed=%b, want %0d/%b/%b",
                 k, count8, led8, changed8, (k >= 7) ? 1 : 0, (k >= 7), (k == 7));
      end
    end
    sw8 = 8'h00;
    settle(10);
    checks++;
    if (count8 !== 4'd0) begin
      errors++;
      $display("FAIL single_bit release: count=%0d want 0", count8);
    end
  endtask

  task automatic test_glitch;
    for (int rep = 0; rep < 5; rep++) begin
      for (int k = 0; k < 6; k++) begin
        sw8[3] = (k < 3);
        @(negedge clk);
        checks++;
        if (count8 !== 4'd0 || changed8 !== 1'b0) begin
          errors++;
          $display("FAIL glitch rep %0d cyc %0d: count=%0d changed=%b, want 0/0", rep, k, count8, changed8);
        end
      end
    end
    sw8 = 8'h00;
    settle(8);
  endtask

  task automatic test_wide_mode;
    sw16 = 16'hFFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (count16 !== ((k >= 7) ? 5'b10000 : 5'd0) || led16 !== 1'b0) begin
        errors++;
        $display("FAIL wide16 edge %0d: count=%0d led=%b, want %0d/0", k, count16, led16, (k >= 7) ? 16 : 0);
      end
    end
    mode16 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (led16 !== (k >= 3) || changed16 !== 1'b0 || count16 !== 5'b10000) begin
        errors++;
        $display("FAIL mode16 edge %0d: led=%b changed=%b count=%0d, want %b/0/16", k, led16, changed16, count16, (k >= 3));
      end
    end
  endtask

  task automatic test_reset_midway;
    int waited = 0;
    sw8 = 8'h0F;
    while (count8 !== 4'd4 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (count8 !== 4'd4) begin
      errors++;
      $display("FAIL midrst_fill: count=%0d want 4 within 20 cycles", count8);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (count8 !== 4'd0 || changed8 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: count=%0d changed=%b want 0/0", count8, changed8);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (count8 !== ((k >= 7) ? 4'd4 : 4'd0) || changed8 !== (k == 7) || led8 !== 1'b0) begin
        errors++;
        $display("FAIL midrst edge %0d: count=%0d changed=%b led=%b, want %0d/%b/0",
                 k, count8, changed8, led8, (k >= 7) ? 4 : 0, (k == 7));
      end
    end
  endtask

  task automatic test_swap_and_random;
    sw8 = 8'h03;
    settle(10);
    checks++;
    if (count8 !== 4'd2 || led8 !== 1'b0) begin
      errors++;
      $display("FAIL swap_pre: count=%0d led=%b want 2/0", count8, led8);
    end
    sw8 = 8'h0C;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (count8 !== 4'd2 || changed8 !== 1'b0 || led8 !== 1'b0) begin
        errors++;
        $display("FAIL swap edge %0d: count=%0d changed=%b led=%b want 2/0/0", k, count8, changed8, led8);
      end
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      checks++;
      if (count8 !== 4'(m_count) || led8 !== m_led || changed8 !== m_changed) begin
        errors++;
        $display("FAIL random cyc %0d: count=%0d led=%b changed=%b, model %0d/%b/%b",
                 c, count8, led8, changed8, m_count, m_led, m_changed);
      end
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 9) == 0) sw8 = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) sw8[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) mode8 = ~mode8;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    sw8    = '0;
    mode8  = 1'b0;
    sw16   = '0;
    mode16 = 1'b0;
    test_reset();
    test_single_bit();
    test_glitch();
    test_wide_mode();
    test_reset_midway();
    test_swap_and_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
